// File: rtl/mem_access_stage.sv
// MEM stage: data-RAM load/store from EX/MEM outputs into MEM/WB registers; optional LED MMIO under `MMIO_EN.
// Latency: WAIT_STATES+1 cycles for a RAM access, 1 cycle for non-memory ops and MMIO.
// Backpressure: Stall_MEM holds the upstream EX/MEM register until the access completes.
module mem_access_stage #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] ALUOut_MEM,
    input  logic [31:0] WriteData_MEM,
    input  logic [4:0]  Rw_MEM,
    input  logic        MemtoReg_MEM,
    input  logic        RegWrite_MEM,
    output logic        Stall_MEM,
    output logic [31:0] ReadData_WB,
    output logic [31:0] ALUOut_WB,
    output logic [4:0]  Rw_WB,
    output logic        MemtoReg_WB,
    output logic        RegWrite_WB,
    output logic        AddrErr_WB,
    output logic [7:0]  led
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef MMIO_EN
    localparam bit MmioOn = 1'b1;
`else
    localparam bit MmioOn = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [31:0]             ram [DEPTH];

    logic                    req;
    logic [ADDR_WIDTH-1:0]   wordIdx;
    logic                    inRange;
    logic                    isMmio;
    logic                    ramHit;
    logic                    addrErr;
    logic                    complete;
    logic                    ramWe;
    logic [31:0]             loadData;

    assign req      = MemRead_MEM | MemWrite_MEM;
    assign wordIdx  = ALUOut_MEM[ADDR_WIDTH+1:2];
    assign inRange  = (ALUOut_MEM >> (ADDR_WIDTH + 2)) == 32'd0;
    assign isMmio   = MmioOn && (ALUOut_MEM == MMIO_BASE);
    assign ramHit   = inRange && !isMmio;
    // Misaligned accesses still use the truncated index; they are only flagged.
    assign addrErr  = req && ((|ALUOut_MEM[1:0]) || (!inRange && !isMmio));
    assign complete = reset && !Stall_MEM;
    assign ramWe    = complete && MemWrite_MEM && ramHit;

    always_comb begin
        Stall_MEM = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: Stall_MEM = req && HAS_WAIT && !isMmio;
                ST_WAIT: Stall_MEM = (cnt != 4'd0);
                default: Stall_MEM = 1'b0;
            endcase
        end
    end

    // Read happens before the same-edge write, so a read+write returns the old word.
    always_comb begin
        loadData = 32'd0;
        if (MemRead_MEM) begin
            if (isMmio)
                loadData = {24'd0, led};
            else if (ramHit)
                loadData = ram[wordIdx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            ReadData_WB <= 32'd0;
            ALUOut_WB   <= 32'd0;
            Rw_WB       <= 5'd0;
            MemtoReg_WB <= 1'b0;
            RegWrite_WB <= 1'b0;
            AddrErr_WB  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Stall_MEM) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (Stall_MEM) begin
                Rw_WB       <= 5'd0;
                MemtoReg_WB <= 1'b0;
                RegWrite_WB <= 1'b0;
                AddrErr_WB  <= 1'b0;
            end else begin
                ReadData_WB <= loadData;
                ALUOut_WB   <= ALUOut_MEM;
                Rw_WB       <= Rw_MEM;
                MemtoReg_WB <= MemtoReg_MEM;
                RegWrite_WB <= RegWrite_MEM;
                AddrErr_WB  <= addrErr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe)
            ram[wordIdx] <= WriteData_MEM;
    end

`ifdef MMIO_EN
    always_ff @(posedge clk) begin
        if (!reset)
            led <= 8'd0;
        else if (complete && MemWrite_MEM && isMmio)
            led <= WriteData_MEM[7:0];
    end
`else
    assign led = 8'd0;
`endif

endmodule
